// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer draw engine: command opcodes,
// FSM states, common RGB565 colours and the byte-swap helper used to put
// a natural-order colour onto the pspi data bus.
package fb_pkg;

   typedef enum logic [1:0] {
      OP_POINT = 2'd0,
      OP_RECT  = 2'd1,
      OP_CLEAR = 2'd2,
      OP_RSVD  = 2'd3
   } fb_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_FIN,
      S_POLL_ISSUE,
      S_POLL_WAIT
   } fb_state_e;

   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] YELLOW = 16'hFFE0;
   localparam logic [15:0] BLACK  = 16'h0000;

   // The framebuffer stores each pixel low byte first.
   function automatic logic [15:0] swap16(input logic [15:0] c);
      return {c[7:0], c[15:8]};
   endfunction

endpackage

// File: rtl/fb_addr_walker.sv
// Bounds/clip evaluation and word-address walk for one draw command.
// start (held for one cycle) loads the walk from the command fields;
// step advances one 32-bit word; last flags the final word of the walk.
module fb_addr_walker
   import fb_pkg::*;
#(
   parameter int          FB_W    = 320,
   parameter int          FB_H    = 240,
   parameter logic [31:0] FB_BASE = 32'd0
) (
   input  logic        clk,
   input  logic        start,
   input  logic        step,
   input  logic [1:0]  op,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] w,
   input  logic [15:0] h,
   output logic        empty,
   output logic        clip,
   output logic        last,
   output logic [31:0] addr
);

   localparam logic [15:0] W_MAX     = 16'(FB_W - 1);
   localparam logic [15:0] H_MAX     = 16'(FB_H - 1);
   localparam logic [31:0] ROW_BYTES = 32'(FB_W * 2);

   logic [16:0] xr, yr;
   logic [15:0] x0, y0, x1, y1, xs;
   logic [31:0] first_row;
   logic [15:0] xs_r, xe_r, y1_r, cx_r, cy_r;
   logic [31:0] row_r;
   logic        row_end;

   // Resolve the inclusive pixel bounds and the clip/empty verdict.
   always_comb begin
      xr    = {1'b0, x} + {1'b0, w} - 17'd1;
      yr    = {1'b0, y} + {1'b0, h} - 17'd1;
      x0    = x;
      y0    = y;
      x1    = x;
      y1    = y;
      empty = 1'b0;
      clip  = 1'b0;
      case (op)
         OP_POINT: ;
         OP_RECT: begin
            if (xr > {1'b0, W_MAX}) begin
               x1   = W_MAX;
               clip = 1'b1;
            end else begin
               x1 = xr[15:0];
            end
            if (yr > {1'b0, H_MAX}) begin
               y1   = H_MAX;
               clip = 1'b1;
            end else begin
               y1 = yr[15:0];
            end
         end
         OP_CLEAR: begin
            x0 = 16'd0;
            y0 = 16'd0;
            x1 = W_MAX;
            y1 = H_MAX;
         end
         default: begin
            empty = 1'b1;
            clip  = 1'b1;
         end
      endcase
      if (x0 > W_MAX || y0 > H_MAX) begin
         empty = 1'b1;
         clip  = 1'b1;
      end else if (op == OP_RECT && (w == 16'd0 || h == 16'd0)) begin
         empty = 1'b1;
         clip  = 1'b0;
      end
   end

   // The only multiply: byte offset of the first row.
   assign xs        = x0 & 16'hFFFE;
   assign first_row = FB_BASE + 32'(y0) * ROW_BYTES;
   assign row_end   = (cx_r | 16'd1) == xe_r;
   assign last      = row_end && (cy_r == y1_r);

   // Word walker: +4 per word, +ROW_BYTES per row, no multiply in the loop.
   always_ff @(posedge clk) begin
      if (start) begin
         xs_r  <= xs;
         xe_r  <= x1 | 16'd1;
         y1_r  <= y1;
         cx_r  <= xs;
         cy_r  <= y0;
         row_r <= first_row;
         addr  <= first_row + {15'd0, xs, 1'b0};
      end else if (step) begin
         if (row_end) begin
            cx_r  <= xs_r;
            cy_r  <= cy_r + 16'd1;
            row_r <= row_r + ROW_BYTES;
            addr  <= row_r + ROW_BYTES + {15'd0, xs_r, 1'b0};
         end else begin
            cx_r <= cx_r + 16'd2;
            addr <= addr + 32'd4;
         end
      end
   end

endmodule

// File: rtl/fb_draw_engine.sv
// Framebuffer draw engine: turns POINT/RECT/CLEAR commands into a stream of
// two-pixel word writes on the pspi bus, one transaction at a time.
// Optional cursor trail polling of the mouse word: define FB_DRAW_CURSOR_EN.
module fb_draw_engine
   import fb_pkg::*;
#(
   parameter int          FB_W         = 320,
   parameter int          FB_H         = 240,
   parameter logic [31:0] FB_BASE      = 32'd0,
   parameter logic [15:0] CURSOR_COLOR = 16'hF800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_x,
   input  logic [15:0] cmd_y,
   input  logic [15:0] cmd_w,
   input  logic [15:0] cmd_h,
   input  logic [15:0] cmd_color,
   output logic        busy,
   output logic        done,
   output logic        clipped,
   output logic [31:0] pspi_a,
   output logic [31:0] pspi_d,
   output logic        pspi_we,
   output logic        pspi_rd,
   input  logic [31:0] pspi_spo,
   input  logic        pspi_ready,
   output logic [15:0] mouse_x,
   output logic [15:0] mouse_y
);

   fb_state_e   state, state_nx;
   logic [1:0]  op_r;
   logic [15:0] x_r, y_r, w_r, h_r, c_r;
   logic        accept, start, step, internal, poll_hit;
   logic        w_empty, w_clip, w_last;
   logic [31:0] w_addr;

   assign accept = cmd_valid && (state == S_IDLE);

   fb_addr_walker #(.FB_W(FB_W), .FB_H(FB_H), .FB_BASE(FB_BASE)) u_walk (
      .clk   (clk),
      .start (start),
      .step  (step),
      .op    (op_r),
      .x     (x_r),
      .y     (y_r),
      .w     (w_r),
      .h     (h_r),
      .empty (w_empty),
      .clip  (w_clip),
      .last  (w_last),
      .addr  (w_addr)
   );

`ifdef FB_DRAW_CURSOR_EN
   logic        internal_r;
   logic [31:0] xy;

   assign xy       = {pspi_spo[7:0], pspi_spo[15:8], pspi_spo[23:16], pspi_spo[31:24]};
   assign poll_hit = (state == S_POLL_WAIT) && pspi_ready && (xy != {mouse_x, mouse_y});
   assign internal = internal_r;

   // Cursor position and the flag marking the in-flight POINT as internal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mouse_x    <= 16'd0;
         mouse_y    <= 16'd0;
         internal_r <= 1'b0;
      end else if (poll_hit) begin
         mouse_x    <= xy[31:16];
         mouse_y    <= xy[15:0];
         internal_r <= 1'b1;
      end else if (accept) begin
         internal_r <= 1'b0;
      end
   end
`else
   logic unused_cursor;

   assign unused_cursor = ^{pspi_spo, CURSOR_COLOR};
   assign poll_hit      = 1'b0;
   assign internal      = 1'b0;
   assign mouse_x       = 16'd0;
   assign mouse_y       = 16'd0;
`endif

   // Command fields, loaded on accept or by a cursor-triggered POINT.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r <= cmd_op;
         x_r  <= cmd_x;
         y_r  <= cmd_y;
         w_r  <= cmd_w;
         h_r  <= cmd_h;
         c_r  <= cmd_color;
`ifdef FB_DRAW_CURSOR_EN
      end else if (poll_hit) begin
         op_r <= OP_POINT;
         x_r  <= xy[31:16];
         y_r  <= xy[15:0];
         w_r  <= 16'd1;
         h_r  <= 16'd1;
         c_r  <= CURSOR_COLOR;
`endif
      end
   end

   // State register and the per-command sticky clip flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         clipped <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept)
            clipped <= 1'b0;
         else if (state == S_SETUP && !internal)
            clipped <= w_clip;
      end
   end

   // Next-state logic and walker control strobes.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      step     = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid)
               state_nx = S_SETUP;
`ifdef FB_DRAW_CURSOR_EN
            else
               state_nx = S_POLL_ISSUE;
`endif
         end
         S_SETUP: begin
            start    = 1'b1;
            state_nx = w_empty ? S_FIN : S_ISSUE;
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (pspi_ready) state_nx = S_NEXT;
         S_NEXT: begin
            if (w_last) begin
               state_nx = S_FIN;
            end else begin
               step     = 1'b1;
               state_nx = S_ISSUE;
            end
         end
         S_FIN: state_nx = S_IDLE;
`ifdef FB_DRAW_CURSOR_EN
         S_POLL_ISSUE: state_nx = S_POLL_WAIT;
         S_POLL_WAIT:  if (pspi_ready) state_nx = poll_hit ? S_SETUP : S_IDLE;
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = !internal && (state inside {S_SETUP, S_ISSUE, S_WAIT, S_NEXT});
   assign done      = !internal && (state == S_FIN);
   assign pspi_we   = (state == S_ISSUE);
   assign pspi_a    = pspi_we ? w_addr : 32'd0;
   assign pspi_d    = pspi_we ? {swap16(c_r), swap16(c_r)} : 32'd0;
`ifdef FB_DRAW_CURSOR_EN
   assign pspi_rd   = (state == S_POLL_ISSUE);
`else
   assign pspi_rd   = 1'b0;
`endif

endmodule

// File: tb/tb_fb_draw_engine.sv
// Bench for fb_draw_engine: a 320x240 instance for the directed scenarios
// and a 16x8 instance (base 0x100) for full-screen clears and random commands.
// Each instance has a pspi responder that raises ready 3 cycles after a strobe.
`timescale 1ns/1ps
module tb_fb_draw_engine;

   logic        clk;
   logic        rst_n;
   logic [1:0]  cmd_valid;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h, cmd_color;
   logic [1:0]  cmd_ready, busy, done, clipped, we, rd, rdy;
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   logic [31:0] spo [2];
   logic [15:0] mx [2];
   logic [15:0] my [2];

   int npass = 0;
   int ncheck = 0;
   int last_base;
   int last_wait;
   logic [63:0] exp_q [$];
   bit exp_clip;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 2; g++) begin : inst
      int cnt = 0;
      int ndone = 0;
      int nrd = 0;
      int nboth = 0;
      logic [63:0] wq [$];

      fb_draw_engine #(
         .FB_W(g == 0 ? 320 : 16), .FB_H(g == 0 ? 240 : 8),
         .FB_BASE(g == 0 ? 32'd0 : 32'h100), .CURSOR_COLOR(16'hF800)
      ) dut (
         .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
         .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
         .cmd_color(cmd_color), .busy(busy[g]), .done(done[g]), .clipped(clipped[g]),
         .pspi_a(pa[g]), .pspi_d(pd[g]), .pspi_we(we[g]), .pspi_rd(rd[g]),
         .pspi_spo(spo[g]), .pspi_ready(rdy[g]), .mouse_x(mx[g]), .mouse_y(my[g])
      );

      assign rdy[g] = (cnt == 1);

      always @(posedge clk) begin
         if (!rst_n) cnt <= 0;
         else if (we[g] || rd[g]) cnt <= 3;
         else if (cnt > 0) cnt <= cnt - 1;
         if (rst_n && we[g]) wq.push_back({pa[g], pd[g]});
         if (rst_n && done[g]) ndone <= ndone + 1;
         if (rst_n && rd[g]) nrd <= nrd + 1;
         if (we[g] && rd[g]) nboth <= nboth + 1;
      end
   end

   function automatic int fbw(input int i); return (i == 0) ? 320 : 16; endfunction
   function automatic int fbh(input int i); return (i == 0) ? 240 : 8; endfunction
   function automatic int fbbase(input int i); return (i == 0) ? 0 : 32'h100; endfunction

   function automatic int qsize(input int i);
      if (i == 0) return inst[0].wq.size();
      return inst[1].wq.size();
   endfunction

   function automatic logic [63:0] qword(input int i, input int k);
      if (i == 0) return inst[0].wq[k];
      return inst[1].wq[k];
   endfunction

   function automatic int ndone_of(input int i);
      if (i == 0) return inst[0].ndone;
      return inst[1].ndone;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      ncheck++;
      assert (obs === expv) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Reference: expected write list straight from the drawing rules.
   task automatic model(input int i, input int op, input int x, input int y,
                        input int w, input int h, input logic [15:0] c);
      int W, H, x0, y0, x1, y1;
      logic [31:0] d;
      W = fbw(i);
      H = fbh(i);
      exp_q.delete();
      exp_clip = 0;
      d = {c[7:0], c[15:8], c[7:0], c[15:8]};
      if (op == 3) begin exp_clip = 1; return; end
      if (op == 2) begin
         x0 = 0; y0 = 0; x1 = W - 1; y1 = H - 1;
      end else begin
         x0 = x; y0 = y;
         if (x0 >= W || y0 >= H) begin exp_clip = 1; return; end
         if (op == 0) begin
            x1 = x0; y1 = y0;
         end else begin
            if (w == 0 || h == 0) return;
            x1 = x0 + w - 1;
            y1 = y0 + h - 1;
            if (x1 > W - 1) begin x1 = W - 1; exp_clip = 1; end
            if (y1 > H - 1) begin y1 = H - 1; exp_clip = 1; end
         end
      end
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0 - (x0 % 2); xx <= x1; xx += 2)
            exp_q.push_back({32'(fbbase(i) + (yy * W + xx) * 2), d});
   endtask

   task automatic send(input int i, input int op, input int x, input int y,
                       input int w, input int h, input logic [15:0] c, input string tag);
      int n;
      @(negedge clk);
      cmd_op = 2'(op); cmd_x = 16'(x); cmd_y = 16'(y);
      cmd_w = 16'(w); cmd_h = 16'(h); cmd_color = c;
      cmd_valid[i] = 1'b1;
      n = 0;
      while (!cmd_ready[i] && n < 100) begin @(negedge clk); n++; end
      last_wait = n;
      check({tag, " accepted"}, 64'(n < 100), 64'd1);
      @(posedge clk); #1;
      cmd_valid[i] = 1'b0;
      @(negedge clk);
      check({tag, " busy/ready after accept"}, {62'd0, busy[i], cmd_ready[i]}, 64'b10);
   endtask

   task automatic run_cmd(input int i, input int op, input int x, input int y,
                          input int w, input int h, input logic [15:0] c, input string tag);
      int n, bad, nd0;
      last_base = qsize(i);
      nd0 = ndone_of(i);
      model(i, op, x, y, w, h, c);
      send(i, op, x, y, w, h, c, tag);
      n = 0;
      while (!done[i] && n < 20000) begin @(negedge clk); n++; end
      check({tag, " done seen"}, 64'(done[i]), 64'd1);
      check({tag, " busy low with done"}, 64'(busy[i]), 64'd0);
      @(negedge clk);
      check({tag, " write count"}, 64'(qsize(i) - last_base), 64'(exp_q.size()));
      bad = 0;
      foreach (exp_q[k]) begin
         if (last_base + k >= qsize(i) || qword(i, last_base + k) !== exp_q[k]) begin
            if (bad == 0)
               $display("  %s: write %0d differs, want %h", tag, k, exp_q[k]);
            bad++;
         end
      end
      check({tag, " write words"}, 64'(bad), 64'd0);
      check({tag, " clipped"}, 64'(clipped[i]), 64'(exp_clip));
      check({tag, " done pulses"}, 64'(ndone_of(i) - nd0), 64'd1);
      check({tag, " ready again"}, 64'(cmd_ready[i]), 64'd1);
   endtask

   initial begin
      int n;
      int ra [6] = '{4, 8, 12, 644, 648, 652};
      rst_n = 1'b0;
      cmd_valid = 2'b00;
      cmd_op = 2'd0; cmd_x = 16'd0; cmd_y = 16'd0;
      cmd_w = 16'd0; cmd_h = 16'd0; cmd_color = 16'd0;
      spo[0] = 32'd0; spo[1] = 32'd0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset%0d flags", i),
               {58'd0, cmd_ready[i], busy[i], done[i], clipped[i], we[i], rd[i]}, 64'b100000);
         check($sformatf("reset%0d bus", i), {pa[i], pd[i]}, 64'd0);
         check($sformatf("reset%0d mouse", i), {32'd0, mx[i], my[i]}, 64'd0);
      end
      rst_n = 1'b1;

      run_cmd(0, 0, 10, 5, 0, 0, 16'hF800, "point");
      check("point word", qword(0, last_base), {32'hC94, 32'h00F800F8});

      run_cmd(0, 1, 3, 0, 4, 2, 16'h07E0, "rect");
      for (int k = 0; k < 6; k++)
         check($sformatf("rect addr %0d", k), 64'(qword(0, last_base + k) >> 32), 64'(ra[k]));

      run_cmd(1, 2, 5, 5, 1, 1, 16'h0000, "clear");
      check("clear first", 64'(qword(1, last_base) >> 32), 64'h100);
      check("clear last", 64'(qword(1, last_base + 63) >> 32), 64'h1FC);

      run_cmd(0, 1, 318, 239, 10, 10, 16'hFFE0, "rect corner");
      check("corner addr", 64'(qword(0, last_base) >> 32), 64'd153596);
      run_cmd(0, 0, 400, 0, 0, 0, 16'hF800, "point off");
      run_cmd(0, 3, 1, 1, 1, 1, 16'hF800, "op3");
      run_cmd(0, 1, 4, 4, 0, 7, 16'hF800, "rect w0");

      for (int r = 0; r < 25; r++)
         run_cmd(1, $urandom_range(0, 3), $urandom_range(0, 19), $urandom_range(0, 10),
                 $urandom_range(0, 20), $urandom_range(0, 10), 16'($urandom),
                 $sformatf("rand%0d", r));

      last_base = qsize(0);
      send(0, 1, 0, 0, 100, 100, 16'hF800, "rst rect");
      n = 0;
      while (qsize(0) - last_base < 7 && n < 1000) begin @(negedge clk); n++; end
      check("rst 7th write", 64'(qsize(0) - last_base), 64'd7);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst abandon", {61'd0, we[0], busy[0], cmd_ready[0]}, 64'b001);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst no more writes", 64'(qsize(0) - last_base), 64'd7);
      run_cmd(0, 0, 7, 9, 0, 0, 16'h1234, "point after rst");

`ifdef FB_DRAW_CURSOR_EN
      begin
         int b, nd;
         b = qsize(0);
         nd = ndone_of(0);
         spo[0] = 32'h05000A00;
         n = 0;
         while (qsize(0) - b < 1 && n < 200) begin @(negedge clk); n++; end
         repeat (10) @(negedge clk);
         check("cursor mouse", {32'd0, mx[0], my[0]}, {32'd0, 16'd10, 16'd5});
         check("cursor word", qword(0, b), {32'hC94, 32'h00F800F8});
         check("cursor no done", 64'(ndone_of(0) - nd), 64'd0);
         repeat (60) @(negedge clk);
         check("cursor repeat no write", 64'(qsize(0) - b), 64'd1);
         n = 0;
         while (!rd[0] && n < 50) begin @(negedge clk); n++; end
         check("poll seen", 64'(rd[0]), 64'd1);
         run_cmd(0, 0, 20, 20, 0, 0, 16'hFFE0, "cmd in poll");
         check("cmd in poll wait", 64'(last_wait >= 1 && last_wait <= 3), 64'd1);
      end
`else
      check("no reads", 64'(inst[0].nrd + inst[1].nrd), 64'd0);
      check("mouse tied", {mx[0], my[0], mx[1], my[1]}, 64'd0);
`endif
      check("we/rd exclusive", 64'(inst[0].nboth + inst[1].nboth), 64'd0);

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule

// File: doc/fb_draw_engine.md
Name: fb_draw_engine

Overview:
Parametrised framebuffer drawing engine that sits between user logic and pspi_host. It accepts point, rectangle-fill and clear-screen commands. Each command becomes a stream of 32-bit two-pixel RGB565 word writes over the pspi a/d/we/rd/ready bus. It replaces hand-coded per-example write FSMs, and optionally tracks the mouse word at address 0 to draw a cursor trail.

Parameters:
FB_W, 320, framebuffer width in pixels (even, ≤ 65534)
FB_H, 240, framebuffer height in pixels (≤ 65535)
FB_BASE, 32'd0, byte address of pixel (0,0)
CURSOR_COLOR, 16'hF800, natural RGB565 cursor colour (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command (high only in IDLE)
cmd_op  in  2  0=POINT, 1=RECT, 2=CLEAR, 3=reserved
cmd_x  in  16  start x
cmd_y  in  16  start y
cmd_w  in  16  rect width in pixels
cmd_h  in  16  rect height in pixels
cmd_color  in  16  natural RGB565 colour
busy  out  1  command in progress
done  out  1  one-cycle pulse at command end
clipped  out  1  sticky per command: set if any part was clipped or the op was illegal; cleared on accept
pspi_a  out  32  byte address to pspi_host
pspi_d  out  32  write data
pspi_we  out  1  one-cycle write strobe
pspi_rd  out  1  one-cycle read strobe
pspi_spo  in  32  read data
pspi_ready  in  1  transaction complete
mouse_x  out  16  last cursor x (0 without feature)
mouse_y  out  16  last cursor y (0 without feature)

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. Outputs: cmd_ready=1, busy=0, done=0, clipped=0, pspi_we=0, pspi_rd=0, pspi_a=0, pspi_d=0, mouse_x=0, mouse_y=0. Reset mid-transaction abandons it immediately; pspi_host is reset by the same net, inverted.
- Accept: cmd_valid & cmd_ready latches all cmd_* fields. Next cycle busy=1 and cmd_ready=0.
- Colour word: c'={c[7:0],c[15:8]}; pspi_d={c',c'}. Example: F800 gives 00F800F8.
- Word granularity: two pixels per word. The x range is widened to xs=x0&~1 through xe=x1|1.
- Address: FB_BASE+(y*FB_W+xs)*2. One multiply is done in SETUP. Afterwards addresses increment by 4 per word and the row base by FB_W*2 per row; there is no multiply in the loop.
- POINT: one word at (x&~1, y).
- RECT: x1=min(x0+w-1, FB_W-1) and y1=min(y0+h-1, FB_H-1), computed in 17 bits. The walk is row-major, left to right, top to bottom.
- CLEAR: full screen with cmd_color; x, y, w and h are ignored.
- Clipping:
  - x0≥FB_W or y0≥FB_H: no writes; clipped=1; done.
  - w=0 or h=0 (RECT): no writes; clipped=0; done.
  - Any truncation of x1 or y1 sets clipped=1.
- op=3: no writes; clipped=1; done.
- FSM: IDLE → SETUP (1 cycle, compute bounds and first address) → ISSUE → WAIT → NEXT → ISSUE or FIN.
  - ISSUE drives a/d and we=1 for exactly one cycle.
  - WAIT ignores pspi_ready in the ISSUE cycle, then waits for pspi_ready=1 with no timeout.
  - NEXT advances x, or wraps to xs and increments y.
  - FIN pulses done for one cycle, then returns to IDLE. done coincides with busy falling.
- Back-to-back: a new command can be accepted the cycle after done (IDLE).
- Only one pspi transaction is outstanding at a time; we and rd are never high together.

Optional Feature:
Macro FB_DRAW_CURSOR_EN.
- With the macro: while in IDLE with no cmd_valid, the engine reads address 0 (POLL_ISSUE: rd=1 for one cycle, then POLL_WAIT for ready).
- The read data is byte-reversed: xy={spo[7:0],spo[15:8],spo[23:16],spo[31:24]}, with x=xy[31:16] and y=xy[15:0].
- If xy differs from the stored value: update mouse_x/mouse_y, then run an internal POINT at (x,y) with CURSOR_COLOR. This internal POINT produces no done pulse and leaves clipped unchanged.
- cmd_ready is 0 during a poll. A pending cmd_valid wins on the first IDLE cycle after the poll.
- Without the macro: no reads are ever issued; pspi_rd is tied 0 and mouse_x/mouse_y are tied 0.

Decomposition:
Shared package fb_pkg holds:
- op encodings (OP_POINT, OP_RECT, OP_CLEAR)
- the FSM state enum
- RGB565 constants RED, YELLOW, BLACK (natural order)
- the swap16 function

One sub-module is natural: fb_addr_walker. It handles the bounds/clip computation, the row and column counters, and address generation, with start/step/last handshakes. The top module keeps the command handshake, the pspi FSM and the cursor poll.

Test Plan:
All scenarios use FB_W=320, FB_H=240, FB_BASE=0, and a pspi model with ready 3 cycles after each strobe.
- POINT (10,5), colour F800: exactly one we, a=0xC94, d=0x00F800F8; then one done pulse, clipped=0.
- RECT x=3 y=0 w=4 h=2: 6 writes in the order a=4, 8, 12, 644, 648, 652; done; clipped=0.
- CLEAR colour 0000: 38400 writes; first a=0, last a=153596; one done pulse.
- RECT (318,239,10,10): one write at a=153596, clipped=1. POINT (400,0): zero writes, done, clipped=1. op=3: zero writes, clipped=1.
- RECT 100×100 with rst_n dropped during the 7th WAIT: the next cycle shows we=0, busy=0, cmd_ready=1. A new POINT accepted afterwards executes normally.
- FB_DRAW_CURSOR_EN: spo=0x05000A00 gives mouse_x=10, mouse_y=5, and one write at a=0xC94 with d=0x00F800F8. A repeated identical spo produces no write. A cmd_valid during a poll is accepted right after that poll.
